bcd_digit_splitter: RTL



---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_add3.sv | 12 +
 rtl/bcd_digit_splitter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the counter/display path: converter states,
// BCD nibble constants and the power-of-ten helper used for the overflow bound.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_NINE    = 4'h9;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import timer_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_digit_splitter.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Optional leading-zero blanking output enabled by defining BCD_SPLITTER_BLANK_EN.
module bcd_digit_splitter
    import timer_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  ovf
`ifdef BCD_SPLITTER_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int          SCR_W    = BCD_W * DIGITS;
    localparam int          CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [63:0] MAX_VAL  = pow10(DIGITS) - 64'd1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [BIN_W-1:0] r_shreg;
    logic [SCR_W-1:0] r_scratch;
    logic [SCR_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_pend;
    logic             r_ovf;

    logic [SCR_W-1:0] w_add3;
    logic [SCR_W-1:0] w_nines;
    logic [SCR_W-1:0] w_scratch_next;
    logic [SCR_W-1:0] w_final;
    logic             w_force;
    logic             w_done;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_scratch[gi*BCD_W +: BCD_W]),
                .o_digit (w_add3[gi*BCD_W +: BCD_W])
            );
            assign w_nines[gi*BCD_W +: BCD_W] = BCD_NINE;
        end
    endgenerate

    // The corrected top bit falls off the scratch on this shift; it can only be
    // set when the value overflows, so it simply reinforces the forced-nines path.
    assign w_scratch_next = {w_add3[SCR_W-2:0], r_shreg[BIN_W-1]};
    assign w_force        = r_ovf_pend | w_add3[SCR_W-1];
    assign w_final        = w_force ? w_nines : w_scratch_next;
    assign w_done         = (r_state == CONV) && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_shreg     <= '0;
            r_scratch   <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_ovf_pend  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shreg    <= bin_in;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (64'(bin_in) > MAX_VAL);
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_scratch <= w_scratch_next;
                    r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_done) begin
                        r_bcd       <= w_final;
                        r_ovf       <= r_ovf_pend;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd_out   = r_bcd;
    assign ovf       = r_ovf;

`ifdef BCD_SPLITTER_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;

    // Digit i blanks when it and every more significant digit are zero.
    assign w_blank[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign w_blank[gi] = (w_final[SCR_W-1:gi*BCD_W] == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blank <= '0;
        end else if (w_done) begin
            r_blank <= w_blank;
        end
    end

    assign blank = r_blank;
`endif

endmodule
